// File: rtl/cu_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, ALU operations,
// FSM state encoding and the control bundle carried across the ID/EX boundary.
package cu_pkg;

   localparam logic [4:0] OP_NOP  = 5'd0;
   localparam logic [4:0] OP_LDD  = 5'd1;
   localparam logic [4:0] OP_STD  = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_NOT  = 5'd4;
   localparam logic [4:0] OP_IN   = 5'd5;
   localparam logic [4:0] OP_OUT  = 5'd6;
   localparam logic [4:0] OP_LDM  = 5'd7;
   localparam logic [4:0] OP_PUSH = 5'd8;
   localparam logic [4:0] OP_POP  = 5'd9;
   localparam logic [4:0] OP_JMP  = 5'd10;
   localparam logic [4:0] OP_CALL = 5'd11;

   localparam logic [2:0] ALU_NONE   = 3'd0;
   localparam logic [2:0] ALU_ADD    = 3'd1;
   localparam logic [2:0] ALU_NOT    = 3'd2;
   localparam logic [2:0] ALU_PASS_B = 3'd3;
   localparam logic [2:0] ALU_ADDR   = 3'd4;

   typedef enum logic [1:0] {
      S_DEC   = 2'd0,
      S_IMM   = 2'd1,
      S_CALL2 = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       alu_src;
      logic       mem_w;
      logic       mem_r;
      logic       mtr;
      logic       reg_write;
      logic       branch;
      logic       in_en;
      logic       out_en;
      logic       stack_op;
      logic       push;
      logic       imm_sel;
      logic       ctrl_valid;
   } ctrl_bundle_t;

   // Bundle issued when the LDM immediate word arrives.
   function automatic ctrl_bundle_t ldm_imm_bundle();
      ctrl_bundle_t b;
      b            = '0;
      b.alu_op     = ALU_PASS_B;
      b.alu_src    = 1'b1;
      b.imm_sel    = 1'b1;
      b.reg_write  = 1'b1;
      b.ctrl_valid = 1'b1;
      return b;
   endfunction

   // Second issue of CALL: the branch to the target.
   function automatic ctrl_bundle_t call_branch_bundle();
      ctrl_bundle_t b;
      b            = '0;
      b.branch     = 1'b1;
      b.ctrl_valid = 1'b1;
      return b;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: single-word bundle, illegal flag and
// markers for the two multi-cycle instructions.
module cu_decode
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 5
) (
   input  logic [OPCODE_W-1:0] opcode,
   output ctrl_bundle_t        bundle,
   output logic                illegal,
   output logic                is_ldm,
   output logic                is_call
);

   logic upper_nz;

   generate
      if (OPCODE_W > 5) begin : g_upper
         assign upper_nz = |opcode[OPCODE_W-1:5];
      end else begin : g_no_upper
         assign upper_nz = 1'b0;
      end
   endgenerate

   always_comb begin
      bundle  = '0;
      illegal = 1'b0;
      is_ldm  = 1'b0;
      is_call = 1'b0;
      if (upper_nz) begin
         illegal = 1'b1;
      end else begin
         case (opcode[4:0])
            OP_NOP: ;
            OP_LDD: begin
               bundle.alu_op     = ALU_ADDR;
               bundle.mem_r      = 1'b1;
               bundle.mtr        = 1'b1;
               bundle.reg_write  = 1'b1;
               bundle.ctrl_valid = 1'b1;
            end
            OP_STD: begin
               bundle.alu_op     = ALU_ADDR;
               bundle.mem_w      = 1'b1;
               bundle.ctrl_valid = 1'b1;
            end
            OP_ADD: begin
               bundle.alu_op     = ALU_ADD;
               bundle.reg_write  = 1'b1;
               bundle.ctrl_valid = 1'b1;
            end
            OP_NOT: begin
               bundle.alu_op     = ALU_NOT;
               bundle.reg_write  = 1'b1;
               bundle.ctrl_valid = 1'b1;
            end
            OP_IN: begin
               bundle.in_en      = 1'b1;
               bundle.reg_write  = 1'b1;
               bundle.ctrl_valid = 1'b1;
            end
            OP_OUT: begin
               bundle.out_en     = 1'b1;
               bundle.ctrl_valid = 1'b1;
            end
            // The opcode word of LDM issues nothing; the immediate word does.
            OP_LDM: is_ldm = 1'b1;
            OP_PUSH: begin
               bundle.stack_op   = 1'b1;
               bundle.push       = 1'b1;
               bundle.mem_w      = 1'b1;
               bundle.ctrl_valid = 1'b1;
            end
            OP_POP: begin
               bundle.stack_op   = 1'b1;
               bundle.mem_r      = 1'b1;
               bundle.mtr        = 1'b1;
               bundle.reg_write  = 1'b1;
               bundle.ctrl_valid = 1'b1;
            end
            OP_JMP: begin
               bundle.branch     = 1'b1;
               bundle.ctrl_valid = 1'b1;
            end
            OP_CALL: begin
               is_call           = 1'b1;
               bundle.stack_op   = 1'b1;
               bundle.push       = 1'b1;
               bundle.mem_w      = 1'b1;
               bundle.ctrl_valid = 1'b1;
            end
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/cu_pipe.sv
// Registered ID-stage control unit: decodes into the ID/EX register and
// sequences LDM (opcode + immediate) and CALL (push + branch) with an FSM.
module cu_pipe
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 5,
   parameter int ALU_OP_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                instr_valid,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                stall,
   input  logic                flush,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                alu_src,
   output logic                mem_w,
   output logic                mem_r,
   output logic                mtr,
   output logic                reg_write,
   output logic                branch,
   output logic                in_en,
   output logic                out_en,
   output logic                stack_op,
   output logic                push,
   output logic                imm_sel,
   output logic                ctrl_valid,
   output logic                fetch_hold,
   output logic                busy,
   output logic                illegal_op
);

   state_t       state_reg, state_next;
   ctrl_bundle_t bundle_reg, bundle_next;
   logic         fetch_hold_reg, fetch_hold_next;
   logic         illegal_reg, illegal_next;

   ctrl_bundle_t dec_bundle;
   logic         dec_illegal;
   logic         dec_is_ldm;
   logic         dec_is_call;

   cu_decode #(
      .OPCODE_W (OPCODE_W)
   ) u_decode (
      .opcode  (opcode),
      .bundle  (dec_bundle),
      .illegal (dec_illegal),
      .is_ldm  (dec_is_ldm),
      .is_call (dec_is_call)
   );

   always_comb begin
      state_next      = state_reg;
      bundle_next     = '0;
      fetch_hold_next = 1'b0;
      illegal_next    = 1'b0;
      case (state_reg)
         S_DEC: begin
            if (instr_valid) begin
               bundle_next  = dec_bundle;
               illegal_next = dec_illegal;
               if (dec_is_ldm) begin
                  state_next = S_IMM;
               end else if (dec_is_call) begin
                  fetch_hold_next = 1'b1;
                  state_next      = S_CALL2;
               end
            end
         end
         S_IMM: begin
            if (instr_valid) begin
               bundle_next = ldm_imm_bundle();
               state_next  = S_DEC;
            end
         end
         S_CALL2: begin
            bundle_next = call_branch_bundle();
            state_next  = S_DEC;
         end
         default: state_next = S_DEC;
      endcase
   end

   // Flush beats stall; a stall freezes everything except the illegal pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_DEC;
         bundle_reg     <= '0;
         fetch_hold_reg <= 1'b0;
         illegal_reg    <= 1'b0;
      end else if (flush) begin
         state_reg      <= S_DEC;
         bundle_reg     <= '0;
         fetch_hold_reg <= 1'b0;
         illegal_reg    <= 1'b0;
      end else if (stall) begin
         illegal_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         bundle_reg     <= bundle_next;
         fetch_hold_reg <= fetch_hold_next;
         illegal_reg    <= illegal_next;
      end
   end

   assign alu_op     = ALU_OP_W'(bundle_reg.alu_op);
   assign alu_src    = bundle_reg.alu_src;
   assign mem_w      = bundle_reg.mem_w;
   assign mem_r      = bundle_reg.mem_r;
   assign mtr        = bundle_reg.mtr;
   assign reg_write  = bundle_reg.reg_write;
   assign branch     = bundle_reg.branch;
   assign in_en      = bundle_reg.in_en;
   assign out_en     = bundle_reg.out_en;
   assign stack_op   = bundle_reg.stack_op;
   assign push       = bundle_reg.push;
   assign imm_sel    = bundle_reg.imm_sel;
   assign ctrl_valid = bundle_reg.ctrl_valid;
   assign fetch_hold = fetch_hold_reg;
   assign busy       = (state_reg != S_DEC);
   assign illegal_op = illegal_reg;

endmodule
